bcd_conv_arbiter: RTL

//   Shares one iterative binary-to-BCD converter (shift-add-3) between NUM_REQ requesters.

---
 rtl/bcd_conv_arbiter_pkg.sv | 33 +++
 rtl/bcd_conv_arbiter_dd_core.sv | 65 ++++++
 rtl/bcd_conv_arbiter.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_conv_arbiter_pkg.sv
// Shared types and helpers for the arbitrated binary-to-BCD converter.
// Imported by bcd_dd_core and bcd_conv_arbiter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  // Largest value that fits in the given number of BCD digits (10^digits - 1).
  function automatic int unsigned max_bcd_val(input int digits);
    int unsigned r;
    r = 1;
    for (int i = 0; i < digits; i++) begin
      r = r * 10;
    end
    return r - 1;
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_conv_arbiter_dd_core.sv
// Iterative shift-add-3 (double dabble) core: operand shifter, BCD scratch
// register, shift counter and a done strobe on the final shift cycle.
module bcd_dd_core
  import bcd_pkg::*;
#(
  parameter int DATA_W = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic [DATA_W-1:0]     operand_i,
  output logic [DIGITS*4-1:0]   bcd_o,
  output logic                  done_o
);

  localparam int CNT_W = clog2(DATA_W + 1);

  logic [DATA_W-1:0]   op_q, op_d;
  logic [DIGITS*4-1:0] scratch_q, scratch_d;
  logic [DIGITS*4-1:0] adj;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Pre-shift correction: any digit >= 5 would overflow past 9 once doubled.
  always_comb begin
    adj = scratch_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch_q[d*4 +: 4] >= 4'd5) begin
        adj[d*4 +: 4] = scratch_q[d*4 +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    op_d      = op_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    if (load_i) begin
      op_d      = operand_i;
      scratch_d = '0;
      cnt_d     = '0;
    end else if (shift_i) begin
      scratch_d = {adj[DIGITS*4-2:0], op_q[DATA_W-1]};
      op_d      = {op_q[DATA_W-2:0], 1'b0};
      cnt_d     = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q      <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
    end else begin
      op_q      <= op_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bcd_o  = scratch_q;
  assign done_o = shift_i && (cnt_q == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one bcd_dd_core between NUM_REQ requesters.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits on bcd_out.
module bcd_conv_arbiter
  import bcd_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 14,
  parameter int DIGITS  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [1:0]                grant_id,
  output logic                      busy,
  output logic [DIGITS*4-1:0]       bcd_out,
  output logic                      bcd_ovf,
  output state_e                    fsm_state_o
);

  // Handshake: req[i] is a level held (with its req_data slice stable) until
  // ack[i]; ack[i] is a one-cycle pulse in the cycle bcd_out/bcd_ovf change.
  // A req still high during its own ack cycle counts as a fresh request.

  localparam logic [31:0]         MAX_VAL = 32'(max_bcd_val(DIGITS));
  localparam logic [DIGITS*4-1:0] ALL_NINES = {DIGITS{4'h9}};

  state_e                state_q, state_d;
  logic [1:0]            grant_id_q, grant_id_d;
  logic [1:0]            rr_q, rr_d;
  logic [DATA_W-1:0]     operand_q, operand_d;
  logic                  ovf_pend_q, ovf_pend_d;
  logic [DIGITS*4-1:0]   bcd_q, bcd_d;
  logic                  ovf_q, ovf_d;
  logic [NUM_REQ-1:0]    ack_q, ack_d;

  logic [1:0]            grant_sel;
  logic                  grant_found;
  logic [DATA_W-1:0]     sel_data;
  logic                  core_load, core_shift, core_done;
  logic [DIGITS*4-1:0]   core_bcd;

`ifdef LEADING_ZERO_BLANK_EN
  // Zero digits above the most significant nonzero digit become the blank code.
  function automatic logic [DIGITS*4-1:0] fmt_digits(input logic [DIGITS*4-1:0] raw);
    logic [DIGITS*4-1:0] r;
    logic                seen;
    r    = raw;
    seen = 1'b0;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      if (!seen && raw[d*4 +: 4] == 4'd0) begin
        r[d*4 +: 4] = DIGIT_BLANK;
      end else begin
        seen = 1'b1;
      end
    end
    return r;
  endfunction
`else
  function automatic logic [DIGITS*4-1:0] fmt_digits(input logic [DIGITS*4-1:0] raw);
    return raw;
  endfunction
`endif

  // First set request at or after the rr pointer, wrapping around.
  always_comb begin
    int idx;
    grant_sel   = 2'd0;
    grant_found = 1'b0;
    idx         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!grant_found && req[j] && (j == idx)) begin
          grant_found = 1'b1;
          grant_sel   = 2'(j);
        end
      end
    end
  end

  always_comb begin
    sel_data = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant_sel == 2'(j)) begin
        sel_data = req_data[j*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    rr_d       = rr_q;
    operand_d  = operand_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    ack_d      = '0;
    core_load  = 1'b0;
    core_shift = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          state_d    = LOAD;
          grant_id_d = grant_sel;
          operand_d  = sel_data;
        end
      end
      LOAD: begin
        core_load = 1'b1;
        // Out-of-range operands skip the shift phase and saturate.
        if (32'(operand_q) > MAX_VAL) begin
          ovf_pend_d = 1'b1;
          state_d    = DONE;
        end else begin
          ovf_pend_d = 1'b0;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        core_shift = 1'b1;
        if (core_done) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        bcd_d   = ovf_pend_q ? ALL_NINES : fmt_digits(core_bcd);
        ovf_d   = ovf_pend_q;
        for (int i = 0; i < NUM_REQ; i++) begin
          ack_d[i] = (grant_id_q == 2'(i));
        end
        rr_d = (grant_id_q == 2'(NUM_REQ - 1)) ? 2'd0 : grant_id_q + 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      grant_id_q <= 2'd0;
      rr_q       <= 2'd0;
      operand_q  <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      grant_id_q <= grant_id_d;
      rr_q       <= rr_d;
      operand_q  <= operand_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      ack_q      <= ack_d;
    end
  end

  bcd_dd_core #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_core (
    .clk       (clk),
    .rst       (rst),
    .load_i    (core_load),
    .shift_i   (core_shift),
    .operand_i (operand_q),
    .bcd_o     (core_bcd),
    .done_o    (core_done)
  );

  // busy covers the ack cycle, which is spent in IDLE.
  assign busy        = (state_q != IDLE) || (|ack_q);
  assign ack         = ack_q;
  assign grant_id    = grant_id_q;
  assign bcd_out     = bcd_q;
  assign bcd_ovf     = ovf_q;
  assign fsm_state_o = state_q;

endmodule
